// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: synchronizer, per-channel glitch filter, x4 decode,
// wrapping signed position, windowed velocity, direction and saturating error count.
module quad_encoder_counter #(
  parameter int FILTER_LEN = 3,
  parameter int VEL_WINDOW = 16000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        zero,
  output logic [31:0] position,
  output logic [31:0] velocity,
  output logic        vel_valid,
  output logic        direction,
  output logic [7:0]  err_count
);

  localparam int WIN_W = $clog2(VEL_WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(VEL_WINDOW - 1);
  localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

  // Channel vectors are packed {A, B} so the filtered vector is the decode state.
  logic [1:0]              sync1_q, sync2_q;
  logic [1:0]              filt_q, filt_d;
  logic [1:0]              prev_q;
  logic [3:0]              fcnt_q [2];
  logic [3:0]              fcnt_d [2];
  logic [WIN_W-1:0]        win_q, win_d;
  logic signed [31:0]      acc_q, acc_d;
  logic signed [31:0]      position_q, position_d;
  logic signed [31:0]      velocity_q, velocity_d;
  logic                    vel_valid_q, vel_valid_d;
  logic                    direction_q, direction_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [1:0]              idx_diff;
  logic                    step_fwd, step_rev, step_bad, win_last;
  logic signed [31:0]      step;

  // Position of a state along the forward Gray cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_idx(input logic [1:0] s);
    case (s)
      2'b00:   gray_idx = 2'd0;
      2'b10:   gray_idx = 2'd1;
      2'b11:   gray_idx = 2'd2;
      default: gray_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FLT_LAST) filt_d[i] = sync2_q[i];
        else                       fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  // A Gray-index distance of 1 is a forward step, 3 reverse, 2 means both bits flipped.
  always_comb begin
    idx_diff = gray_idx(filt_q) - gray_idx(prev_q);
    step_fwd = (idx_diff == 2'd1);
    step_rev = (idx_diff == 2'd3);
    step_bad = (idx_diff == 2'd2);
    if (step_fwd)      step = 32'sd1;
    else if (step_rev) step = -32'sd1;
    else               step = 32'sd0;
  end

  always_comb begin
    position_d  = zero ? 32'sd0 : position_q + step;
    direction_d = step_fwd ? 1'b1 : (step_rev ? 1'b0 : direction_q);
    err_count_d = step_bad ? sat_inc8(err_count_q) : err_count_q;
    win_last    = (win_q == WIN_LAST);
    win_d       = win_last ? '0 : win_q + WIN_W'(1);
    acc_d       = win_last ? 32'sd0 : acc_q + step;
    velocity_d  = win_last ? acc_q + step : velocity_q;
    vel_valid_d = win_last;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      prev_q      <= '0;
      fcnt_q[0]   <= '0;
      fcnt_q[1]   <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      position_q  <= '0;
      velocity_q  <= '0;
      vel_valid_q <= 1'b0;
      direction_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      sync1_q     <= {enc_a, enc_b};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      prev_q      <= filt_q;
      fcnt_q[0]   <= fcnt_d[0];
      fcnt_q[1]   <= fcnt_d[1];
      win_q       <= win_d;
      acc_q       <= acc_d;
      position_q  <= position_d;
      velocity_q  <= velocity_d;
      vel_valid_q <= vel_valid_d;
      direction_q <= direction_d;
      err_count_q <= err_count_d;
    end
  end

  assign position  = position_q;
  assign velocity  = velocity_q;
  assign vel_valid = vel_valid_q;
  assign direction = direction_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed bench for quad_encoder_counter with FILTER_LEN=3 and a 100-cycle velocity window.
module tb_quad_encoder_counter;
  localparam int FL = 3;
  localparam int VW = 100;

  logic        CLK = 1'b0;
  logic        reset, enc_a, enc_b, zero;
  logic [31:0] position, velocity;
  logic        vel_valid, direction;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [1:0] fwd [4] = '{2'b10, 2'b11, 2'b01, 2'b00};

  quad_encoder_counter #(.FILTER_LEN(FL), .VEL_WINDOW(VW)) dut (
    .CLK(CLK), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .zero(zero),
    .position(position), .velocity(velocity), .vel_valid(vel_valid),
    .direction(direction), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic drive(input logic [1:0] s, input int hold);
    {enc_a, enc_b} = s;
    ticks(hold);
  endtask

  initial begin
    reset = 1'b1; enc_a = 1'b0; enc_b = 1'b0; zero = 1'b0;
    #2;
    check("rst_pos", position, 32'h0);
    check("rst_vel", velocity, 32'h0);
    check("rst_vld", vel_valid, 32'h0);
    check("rst_dir", direction, 32'h0);
    check("rst_err", err_count, 32'h0);
    ticks(2);
    reset = 1'b0;
    cyc = 0;

    // Forward rotation, two full cycles; first step 2+FL edges after capture edge.
    ticks(3);
    {enc_a, enc_b} = 2'b10;
    ticks(5);
    check("t1_lat_before", position, 32'd0);
    tick();
    check("t1_lat", position, 32'd1);
    ticks(4);
    drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
    drive(2'b10, 10); drive(2'b11, 10); drive(2'b01, 10); drive(2'b00, 10);
    check("t1_pos", position, 32'd8);
    check("t1_dir", direction, 32'd1);
    check("t1_err", err_count, 32'd0);

    // Reverse from reset, then zero coinciding with a forward step.
    do_reset();
    drive(2'b01, 10); drive(2'b11, 10); drive(2'b10, 10); drive(2'b00, 10);
    check("t2_pos", position, 32'hFFFF_FFFC);
    check("t2_dir", direction, 32'd0);
    {enc_a, enc_b} = 2'b10;
    ticks(5);
    zero = 1'b1;
    tick();
    zero = 1'b0;
    check("t2_zero", position, 32'd0);
    check("t2_zero_dir", direction, 32'd1);
    ticks(5);
    check("t2_zero_hold", position, 32'd0);

    // Glitch filter: 2-cycle pulse rejected, 3-cycle pulse accepted.
    do_reset();
    enc_a = 1'b1; ticks(2); enc_a = 1'b0;
    ticks(10);
    check("t3_short", position, 32'd0);
    enc_a = 1'b1; ticks(3); enc_a = 1'b0;
    ticks(4);
    check("t3_accept", position, 32'd1);
    ticks(10);
    check("t3_return", position, 32'd0);
    check("t3_err", err_count, 32'd0);

    // Illegal double transitions and error saturation.
    do_reset();
    drive(2'b11, 8);
    check("t4_err1", err_count, 32'd1);
    check("t4_pos1", position, 32'd0);
    for (int i = 0; i < 300; i++) begin
      drive((i % 2 == 0) ? 2'b00 : 2'b11, 8);
      if (i == 8) check("t4_err10", err_count, 32'd10);
    end
    check("t4_sat", err_count, 32'd255);
    check("t4_pos", position, 32'd0);
    check("t4_dir", direction, 32'd0);

    // Velocity windows: 10 forward, then 3 reverse with the last in the closing cycle.
    do_reset();
    for (int k = 0; k < 10; k++) drive(fwd[k % 4], 7);
    ticks(99 - cyc);
    check("t5_pre_vld", vel_valid, 32'd0);
    tick();
    check("t5_vld1", vel_valid, 32'd1);
    check("t5_vel1", velocity, 32'd10);
    tick();
    check("t5_vld1_off", vel_valid, 32'd0);
    ticks(120 - cyc); {enc_a, enc_b} = 2'b10;
    ticks(150 - cyc); {enc_a, enc_b} = 2'b00;
    ticks(194 - cyc); {enc_a, enc_b} = 2'b01;
    ticks(199 - cyc);
    check("t5_pos199", position, 32'd8);
    check("t5_pre_vld2", vel_valid, 32'd0);
    tick();
    check("t5_vld2", vel_valid, 32'd1);
    check("t5_vel2", velocity, 32'hFFFF_FFFD);
    check("t5_pos200", position, 32'd7);
    check("t5_dir", direction, 32'd0);

    // Reset mid-window with A held high.
    do_reset();
    for (int k = 0; k < 5; k++) drive(fwd[k % 4], 10);
    check("t6_pos5", position, 32'd5);
    reset = 1'b1;
    #1;
    check("t6_rst_pos", position, 32'd0);
    check("t6_rst_vel", velocity, 32'd0);
    check("t6_rst_vld", vel_valid, 32'd0);
    check("t6_rst_dir", direction, 32'd0);
    check("t6_rst_err", err_count, 32'd0);
    ticks(2);
    reset = 1'b0;
    cyc = 0;
    // The first post-release edge captures A; the step follows 2+FL edges later.
    ticks(2 + FL);
    check("t6_pos_before", position, 32'd0);
    tick();
    check("t6_pos_step", position, 32'd1);
    check("t6_dir", direction, 32'd1);
    while (!vel_valid && cyc < 300) tick();
    check("t6_vel_first", cyc, 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
